reg_write_ctrl: RTL and testbench
=================================

Name: reg_write_ctrl

Overview:
- Parametrised write-port controller for the ALU register file. Generalises the one-hot write-address decode to DEPTH registers and adds a command/data handshake with auto-incrementing burst writes.
- Produces a registered one-hot write strobe plus write data to the register bank.
- Sits between the control sequencer (command source) and the register file (strobe sink).

Parameters:
- DATA_W, 8, width of write data.
- DEPTH, 8, number of registers; width of one-hot strobe; 2..256.
- ADDR_W, 8, width of register address.
- LEN_W, 4, width of burst length field; burst beats = req_len+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  command valid.
- req_ready  output  1  command accepted when req_valid&req_ready.
- req_addr  input  ADDR_W  burst start register address.
- req_len  input  LEN_W  burst beats minus one.
- dat_valid  input  1  data beat valid; no backpressure, accepted only while dat_ready=1.
- dat_ready  output  1  high in BURST state.
- dat_in  input  DATA_W  beat data.
- to_reg  output  DEPTH  registered one-hot write strobe, bit n writes register n.
- wr_data  output  DATA_W  registered data aligned with to_reg.
- busy  output  1  high while a burst is open.
- err  output  1  one-cycle pulse on rejected command or suppressed beat.
- lock  input  DEPTH  per-register write lock; present only with RWC_LOCK_EN.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, to_reg=0, wr_data=0, busy=0, err=0, req_ready=0, dat_ready=0, internal addr/count=0. req_ready rises on the first clk edge after reset_n release. Reset mid-burst aborts the burst immediately, with no further strobes.
- States: IDLE, BURST. All outputs are registered.
- IDLE:
  - req_ready=1, dat_ready=0, busy=0. dat_valid is ignored.
  - On accept with req_addr<DEPTH: latch cur_addr=req_addr, remaining=req_len. Next cycle state=BURST, busy=1, req_ready=0, dat_ready=1.
  - On accept with req_addr>=DEPTH: err=1 for one cycle, no strobe, stay IDLE, req_ready stays 1.
- BURST:
  - Each cycle with dat_valid=1 is one beat. Next cycle to_reg=one-hot(cur_addr) and wr_data=dat_in; strobe latency is 1 cycle from beat.
  - After each beat: cur_addr increments and wraps from DEPTH-1 to 0; remaining decrements.
  - The beat with remaining=0 is the last beat. Next cycle: state=IDLE, busy=0, dat_ready=0, req_ready=1.
  - Cycles with dat_valid=0 produce to_reg=0. wr_data holds its last value. No timeout.
  - req_valid is ignored in BURST; no command is accepted until return to IDLE.
- to_reg is zero in every cycle without an accepted beat. It never has more than one bit set.
- Bursts longer than DEPTH wrap and rewrite the earliest registers in order.
- Back-to-back: a command accepted in the first IDLE cycle after a burst is legal, giving a minimum 1-cycle IDLE gap between bursts.

Optional Feature:
- Macro RWC_LOCK_EN.
- Defined:
  - lock port exists.
  - A beat targeting a register whose lock bit is 1 gives to_reg=0 and err=1 in the strobe cycle. The beat still consumes address and count.
  - A command whose start address is locked is still accepted.
- Undefined: lock port absent and all registers writable. err is driven only by out-of-range commands.

Test Plan:
- Reset release: hold reset_n=0 for 3 cycles -> all outputs 0; req_ready=1 one edge after release.
- Single write: addr=3, len=0, beat dat_in=8'hA5 -> next cycle to_reg=8'b0000_1000, wr_data=8'hA5; then IDLE, busy=0.
- Wrap burst: addr=6, len=3, beats 11,22,33,44 with dat_valid gap after beat 2 -> strobes 0x40,0x80,(0),0x01,0x02 with matching data; busy drops after last.
- Out-of-range: addr=8'h08 -> err pulse 1 cycle, to_reg stays 0, req_ready stays 1; addr=8'hFF same.
- Mid-burst reset: addr=0, len=7, assert reset_n=0 after beat 3 -> to_reg/busy go 0 asynchronously; no strobes after release until a new command.
- RWC_LOCK_EN: lock=8'b0000_0100, addr=1, len=2 -> strobes 0x02, (0 with err=1), 0x08.

Source files
------------

// File: rtl/reg_write_ctrl.sv
// -----------------------------------------------------------------------------
// reg_write_ctrl
//   Write-port controller for the ALU register file. Accepts a burst command
//   (start address + beat count) from the control sequencer, then turns each
//   accepted data beat into a registered one-hot write strobe plus write data.
//   The address auto-increments and wraps from DEPTH-1 to 0.
//
// Optional feature (macro RWC_LOCK_EN):
//   Adds the per-register `lock` input. A beat aimed at a locked register is
//   suppressed (no strobe) and pulses err, but still consumes address/count.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   command valid
//   req_ready  out  command accepted when req_valid & req_ready (IDLE only)
//   req_addr   in   [ADDR_W] burst start register address
//   req_len    in   [LEN_W]  burst beats minus one
//   dat_valid  in   data beat valid (accepted only while dat_ready)
//   dat_ready  out  high while in BURST
//   dat_in     in   [DATA_W] beat data
//   to_reg     out  [DEPTH]  registered one-hot write strobe
//   wr_data    out  [DATA_W] registered write data aligned with to_reg
//   busy       out  high while a burst is open
//   err        out  one-cycle pulse: out-of-range command or suppressed beat
//   lock       in   [DEPTH]  per-register write lock (RWC_LOCK_EN only)
// -----------------------------------------------------------------------------
module reg_write_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              dat_valid,
  output logic              dat_ready,
  input  logic [DATA_W-1:0] dat_in,
  output logic [DEPTH-1:0]  to_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
`ifdef RWC_LOCK_EN
  output logic              err,
  input  logic [DEPTH-1:0]  lock
`else
  output logic              err
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DEPTH-1:0]  to_reg_q, to_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              req_ready_q, req_ready_d;
  logic              dat_ready_q, dat_ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [DEPTH-1:0]  onehot;
  logic              addr_in_range;
  logic              beat_blocked;

  // Zero-extend before comparing so DEPTH=256 with ADDR_W=8 works.
  assign addr_in_range = (32'(req_addr) < DEPTH);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cur_addr_q == ADDR_W'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef RWC_LOCK_EN
  assign beat_blocked = |(onehot & lock);
`else
  assign beat_blocked = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    to_reg_d    = '0;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // req_ready_q gates acceptance so nothing is taken in the first
        // cycle after reset release.
        if (req_valid && req_ready_q) begin
          if (addr_in_range) begin
            cur_addr_d  = req_addr;
            remaining_d = req_len;
            state_d     = BURST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (dat_valid) begin
          if (beat_blocked) begin
            err_d = 1'b1;
          end else begin
            to_reg_d  = onehot;
            wr_data_d = dat_in;
          end
          cur_addr_d = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + 1'b1;
          if (remaining_q == '0) begin
            state_d = IDLE;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status flags are registered copies of the next state.
    req_ready_d = (state_d == IDLE);
    dat_ready_d = (state_d == BURST);
    busy_d      = (state_d == BURST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      to_reg_q    <= '0;
      wr_data_q   <= '0;
      req_ready_q <= 1'b0;
      dat_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      to_reg_q    <= to_reg_d;
      wr_data_q   <= wr_data_d;
      req_ready_q <= req_ready_d;
      dat_ready_q <= dat_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign dat_ready = dat_ready_q;
  assign to_reg    = to_reg_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_write_ctrl
//   Directed bench for reg_write_ctrl with DATA_W=8, DEPTH=8, ADDR_W=8,
//   LEN_W=4. Inputs change 1 time unit after a rising edge; outputs are
//   sampled at the same point, reflecting that edge.
// -----------------------------------------------------------------------------
module tb_reg_write_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       dat_valid;
  logic       dat_ready;
  logic [7:0] dat_in;
  logic [7:0] to_reg;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;
`ifdef RWC_LOCK_EN
  logic [7:0] lock;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_write_ctrl #(
    .DATA_W(8),
    .DEPTH (8),
    .ADDR_W(8),
    .LEN_W (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .dat_valid(dat_valid),
    .dat_ready(dat_ready),
    .dat_in   (dat_in),
    .to_reg   (to_reg),
    .wr_data  (wr_data),
    .busy     (busy),
`ifdef RWC_LOCK_EN
    .err      (err),
    .lock     (lock)
`else
    .err      (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic [7:0] exp_strobe, input string tag);
    dat_valid = 1'b1;
    dat_in    = d;
    tick();
    check({tag, " to_reg"}, 32'(to_reg), 32'(exp_strobe));
    check({tag, " wr_data"}, 32'(wr_data), 32'(d));
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    dat_valid = 1'b0;
    dat_in    = '0;
`ifdef RWC_LOCK_EN
    lock      = '0;
`endif

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst to_reg", 32'(to_reg), 32'h0);
    check("rst wr_data", 32'(wr_data), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst err", 32'(err), 32'h0);
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst dat_ready", 32'(dat_ready), 32'h0);

    reset_n = 1'b1;
    tick();
    check("post-rst req_ready", 32'(req_ready), 32'h1);
    check("post-rst dat_ready", 32'(dat_ready), 32'h0);

    // Single write: addr 3, len 0
    req_valid = 1'b1; req_addr = 8'd3; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    check("single busy", 32'(busy), 32'h1);
    check("single dat_ready", 32'(dat_ready), 32'h1);
    check("single req_ready", 32'(req_ready), 32'h0);
    check("single pre to_reg", 32'(to_reg), 32'h0);
    beat(8'hA5, 8'b0000_1000, "single");
    check("single end busy", 32'(busy), 32'h0);
    check("single end req_ready", 32'(req_ready), 32'h1);
    dat_valid = 1'b0;
    tick();
    check("idle to_reg", 32'(to_reg), 32'h0);
    check("idle wr_data hold", 32'(wr_data), 32'hA5);

    // Wrap burst: addr 6, len 3, gap after beat 2, req_valid ignored in gap
    req_valid = 1'b1; req_addr = 8'd6; req_len = 4'd3;
    tick();
    req_valid = 1'b0;
    beat(8'h11, 8'h40, "wrap b0");
    beat(8'h22, 8'h80, "wrap b1");
    dat_valid = 1'b0; req_valid = 1'b1; req_addr = 8'd0; req_len = 4'd0;
    tick();
    check("wrap gap to_reg", 32'(to_reg), 32'h0);
    check("wrap gap wr_data", 32'(wr_data), 32'h22);
    check("wrap gap busy", 32'(busy), 32'h1);
    check("wrap gap req_ready", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    beat(8'h33, 8'h01, "wrap b2");
    check("wrap mid busy", 32'(busy), 32'h1);
    beat(8'h44, 8'h02, "wrap b3");
    check("wrap end busy", 32'(busy), 32'h0);
    check("wrap end req_ready", 32'(req_ready), 32'h1);
    dat_valid = 1'b0;

    // Out-of-range commands
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_addr = (k == 0) ? 8'h08 : 8'hFF; req_len = 4'd2;
      tick();
      req_valid = 1'b0;
      check("oor err", 32'(err), 32'h1);
      check("oor to_reg", 32'(to_reg), 32'h0);
      check("oor req_ready", 32'(req_ready), 32'h1);
      check("oor busy", 32'(busy), 32'h0);
      tick();
      check("oor err clr", 32'(err), 32'h0);
    end

    // Mid-burst reset: addr 0, len 7, reset after beat 3
    req_valid = 1'b1; req_addr = 8'd0; req_len = 4'd7;
    tick();
    req_valid = 1'b0;
    beat(8'h01, 8'h01, "mid b0");
    beat(8'h02, 8'h02, "mid b1");
    beat(8'h03, 8'h04, "mid b2");
    dat_in = 8'h04;
    #2 reset_n = 1'b0;
    #1;
    check("mid async to_reg", 32'(to_reg), 32'h0);
    check("mid async busy", 32'(busy), 32'h0);
    check("mid async wr_data", 32'(wr_data), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post-abort to_reg", 32'(to_reg), 32'h0);
      check("post-abort busy", 32'(busy), 32'h0);
    end
    check("post-abort req_ready", 32'(req_ready), 32'h1);
    dat_valid = 1'b0;

`ifdef RWC_LOCK_EN
    // Locked register 2 inside a burst from 1
    lock = 8'b0000_0100;
    req_valid = 1'b1; req_addr = 8'd1; req_len = 4'd2;
    tick();
    req_valid = 1'b0;
    beat(8'hB1, 8'h02, "lock b0");
    check("lock b0 err", 32'(err), 32'h0);
    dat_valid = 1'b1; dat_in = 8'hB2;
    tick();
    check("lock b1 to_reg", 32'(to_reg), 32'h0);
    check("lock b1 err", 32'(err), 32'h1);
    beat(8'hB3, 8'h08, "lock b2");
    check("lock b2 err", 32'(err), 32'h0);
    check("lock end busy", 32'(busy), 32'h0);
    dat_valid = 1'b0;
    lock = '0;
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
